// File: rtl/audio_atten_pkg.sv
// Shared types, constants and gain helpers for the stereo attenuation matrix.
package audio_atten_pkg;

  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned CODE_W    = 8;
  localparam int unsigned MANT_W    = 17;
  localparam int unsigned SHIFT_W   = 4;
  localparam int unsigned SUM_W     = 18;
  localparam int unsigned NUM_PATHS = 4;

  // Path indices into the packed per-path arrays (xy = source x to output y)
  localparam int unsigned P_LL = 0;
  localparam int unsigned P_LR = 1;
  localparam int unsigned P_RL = 2;
  localparam int unsigned P_RR = 3;

  localparam logic [CODE_W-1:0] MUTE_CODE = CODE_W'(128);

  typedef enum logic [2:0] {
    IDLE,
    MUL_LL,
    MUL_RL,
    MUL_LR,
    MUL_RR,
    SUM
  } state_t;

  // Mantissa is Q1.15 carried as a 17-bit signed value (32768 needs the extra bit)
  typedef struct packed {
    logic [MANT_W-1:0]  mant;
    logic [SHIFT_W-1:0] shift;
  } gain_t;

  // Codes at or above mute collapse to the mute code
  function automatic logic [CODE_W-1:0] clamp_code(input logic [CODE_W-1:0] code);
    return (code >= MUTE_CODE) ? MUTE_CODE : code;
  endfunction

  // 0.5 dB step table: mantissa from code%12, extra right shift from code/12; mute gives zero
  function automatic gain_t mant_lookup(input logic [CODE_W-1:0] code);
    gain_t g;
    logic [CODE_W-1:0] idx;
    g.mant  = '0;
    g.shift = '0;
    idx     = code % CODE_W'(12);
    if (code < MUTE_CODE) begin
      g.shift = SHIFT_W'(code / CODE_W'(12));
      case (idx)
        8'd0:    g.mant = 17'd32768;
        8'd1:    g.mant = 17'd30935;
        8'd2:    g.mant = 17'd29205;
        8'd3:    g.mant = 17'd27571;
        8'd4:    g.mant = 17'd26029;
        8'd5:    g.mant = 17'd24573;
        8'd6:    g.mant = 17'd23198;
        8'd7:    g.mant = 17'd21900;
        8'd8:    g.mant = 17'd20675;
        8'd9:    g.mant = 17'd19519;
        8'd10:   g.mant = 17'd18427;
        default: g.mant = 17'd17396;
      endcase
    end
    return g;
  endfunction

  // Clamp an 18-bit signed sum into the 16-bit signed output range
  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SUM_W-1:0] s);
    if (s > 18'sd32767) begin
      return 16'sh7FFF;
    end else if (s < -18'sd32768) begin
      return 16'sh8000;
    end else begin
      return SAMPLE_W'(s);
    end
  endfunction

endpackage

// File: rtl/audio_gain_mul.sv
// Shared signed sample x Q1.15 mantissa multiplier with flooring right shift.
module audio_gain_mul
  import audio_atten_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic signed [MANT_W-1:0]   mant,
  input  logic        [SHIFT_W-1:0]  shift,
  output logic signed [SUM_W-1:0]    product_c
);

  localparam int unsigned PROD_W = SAMPLE_W + MANT_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] shifted;

  // Full-precision product, arithmetic shift floors toward -inf; result always fits 16 bits
  always_comb begin
    prod      = PROD_W'(sample) * PROD_W'(mant);
    shifted   = prod >>> (6'd15 + 6'(shift));
    product_c = SUM_W'(shifted);
  end

endmodule

// File: rtl/audio_attenuator.sv
// Stereo 2x2 attenuation matrix with per-sample ramping and one time-shared multiplier.
module audio_attenuator
  import audio_atten_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_strobe,
  input  logic signed [SAMPLE_W-1:0] in_left,
  input  logic signed [SAMPLE_W-1:0] in_right,
  input  logic        [CODE_W-1:0]   atten_ll,
  input  logic        [CODE_W-1:0]   atten_lr,
  input  logic        [CODE_W-1:0]   atten_rl,
  input  logic        [CODE_W-1:0]   atten_rr,
  input  logic                       atten_apply,
  output logic signed [SAMPLE_W-1:0] out_left,
  output logic signed [SAMPLE_W-1:0] out_right,
  output logic                       out_strobe,
  output logic                       busy,
  output logic                       overrun
);

  state_t state, state_next;

  logic signed [SAMPLE_W-1:0] smp_l, smp_r;
  logic signed [SUM_W-1:0]    p_ll, p_rl, p_lr;

  logic [NUM_PATHS-1:0][CODE_W-1:0] cur_q;
  logic [NUM_PATHS-1:0][CODE_W-1:0] tgt_q;
  logic [NUM_PATHS-1:0][CODE_W-1:0] tgt_eff;
  logic [NUM_PATHS-1:0][CODE_W-1:0] atten_vec;

  logic signed [SAMPLE_W-1:0] mul_sample;
  logic        [CODE_W-1:0]   mul_code;
  gain_t                      mul_gain;
  logic signed [SUM_W-1:0]    mul_prod;

  logic capture;
  logic load_out;

  assign atten_vec = {atten_rr, atten_rl, atten_lr, atten_ll};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    load_out   = 1'b0;
    case (state)
      IDLE: begin
        if (sample_strobe) begin
          state_next = MUL_LL;
          capture    = 1'b1;
        end
      end
      MUL_LL: state_next = MUL_RL;
      MUL_RL: state_next = MUL_LR;
      MUL_LR: state_next = MUL_RR;
      MUL_RR: begin
        state_next = SUM;
        load_out   = 1'b1;
      end
      SUM:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Route the current path's sample and ramped code to the shared multiplier
  always_comb begin
    mul_sample = smp_l;
    mul_code   = cur_q[P_LL];
    case (state)
      MUL_RL: begin
        mul_sample = smp_r;
        mul_code   = cur_q[P_RL];
      end
      MUL_LR: begin
        mul_sample = smp_l;
        mul_code   = cur_q[P_LR];
      end
      MUL_RR: begin
        mul_sample = smp_r;
        mul_code   = cur_q[P_RR];
      end
      default: ;
    endcase
    mul_gain = mant_lookup(mul_code);
  end

  audio_gain_mul u_gain_mul (
    .sample    (mul_sample),
    .mant      ($signed(mul_gain.mant)),
    .shift     (mul_gain.shift),
    .product_c (mul_prod)
  );

  // Targets a same-cycle apply would install, so a coinciding SUM ramps toward them
  always_comb begin
    tgt_eff = tgt_q;
    for (int unsigned i = 0; i < NUM_PATHS; i++) begin
      if (atten_apply) begin
        tgt_eff[i] = clamp_code(atten_vec[i]);
      end
    end
  end

  // Sample capture, product staging, outputs and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      smp_l      <= '0;
      smp_r      <= '0;
      p_ll       <= '0;
      p_rl       <= '0;
      p_lr       <= '0;
      out_left   <= '0;
      out_right  <= '0;
      out_strobe <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (capture) begin
        smp_l <= in_left;
        smp_r <= in_right;
      end
      if (state == MUL_LL) p_ll <= mul_prod;
      if (state == MUL_RL) p_rl <= mul_prod;
      if (state == MUL_LR) p_lr <= mul_prod;
      if (load_out) begin
        out_left  <= sat16(p_ll + p_rl);
        out_right <= sat16(p_lr + mul_prod);
      end
      out_strobe <= load_out;
      busy       <= (state_next != IDLE);
      if (sample_strobe && (state != IDLE)) overrun <= 1'b1;
    end
  end

  // Target latch on apply
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgt_q <= {NUM_PATHS{MUTE_CODE}};
    end else if (atten_apply) begin
      tgt_q <= tgt_eff;
    end
  end

  // One-step ramp of each path toward its target once the sample's outputs are out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_q <= {NUM_PATHS{MUTE_CODE}};
    end else if (state == SUM) begin
      for (int unsigned i = 0; i < NUM_PATHS; i++) begin
        if (cur_q[i] < tgt_eff[i]) begin
          cur_q[i] <= cur_q[i] + CODE_W'(1);
        end else if (cur_q[i] > tgt_eff[i]) begin
          cur_q[i] <= cur_q[i] - CODE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_attenuator.sv
// Self-checking bench for audio_attenuator against a behavioural gain-matrix model.
module tb_audio_attenuator;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               sample_strobe;
  logic signed [15:0] in_left, in_right;
  logic        [7:0]  atten_ll, atten_lr, atten_rl, atten_rr;
  logic               atten_apply;
  logic signed [15:0] out_left, out_right;
  logic               out_strobe, busy, overrun;

  int errors = 0;
  int checks = 0;

  // Model state: index 0=ll 1=lr 2=rl 3=rr
  int m_cur[4];
  int m_tgt[4];
  int mant_tab[12] = '{32768, 30935, 29205, 27571, 26029, 24573,
                       23198, 21900, 20675, 19519, 18427, 17396};

  audio_attenuator dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sample_strobe (sample_strobe),
    .in_left       (in_left),
    .in_right      (in_right),
    .atten_ll      (atten_ll),
    .atten_lr      (atten_lr),
    .atten_rl      (atten_rl),
    .atten_rr      (atten_rr),
    .atten_apply   (atten_apply),
    .out_left      (out_left),
    .out_right     (out_right),
    .out_strobe    (out_strobe),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int path_gain(int x, int code);
    longint p;
    if (code >= 128) return 0;
    p = longint'(x) * longint'(mant_tab[code % 12]);
    return int'(p >>> (15 + code / 12));
  endfunction

  function automatic int sat_ref(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int clamp_ref(int c);
    return (c > 128) ? 128 : c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cur[i] = 128;
      m_tgt[i] = 128;
    end
  endtask

  task automatic model_ramp();
    for (int i = 0; i < 4; i++) begin
      if (m_cur[i] < m_tgt[i]) m_cur[i]++;
      else if (m_cur[i] > m_tgt[i]) m_cur[i]--;
    end
  endtask

  task automatic model_targets_from_inputs();
    m_tgt[0] = clamp_ref(int'(atten_ll));
    m_tgt[1] = clamp_ref(int'(atten_lr));
    m_tgt[2] = clamp_ref(int'(atten_rl));
    m_tgt[3] = clamp_ref(int'(atten_rr));
  endtask

  task automatic apply(input int ll, input int lr, input int rl, input int rr);
    atten_ll = 8'(ll); atten_lr = 8'(lr); atten_rl = 8'(rl); atten_rr = 8'(rr);
    atten_apply = 1'b1;
    model_targets_from_inputs();
    tick();
    atten_apply = 1'b0;
  endtask

  // Send one sample at cycle N, check strobe timing and outputs at N+5; returns at N+6
  task automatic send(input logic signed [15:0] l, input logic signed [15:0] r, input bit apply_sum);
    int el, er;
    el = sat_ref(path_gain(int'(l), m_cur[0]) + path_gain(int'(r), m_cur[2]));
    er = sat_ref(path_gain(int'(l), m_cur[1]) + path_gain(int'(r), m_cur[3]));
    in_left = l; in_right = r; sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_n1: got %b want 1", busy);
    end
    for (int k = 1; k < 5; k++) begin
      checks++;
      if (out_strobe !== 1'b0) begin
        errors++; $display("FAIL early_strobe: cycle N+%0d got %b want 0", k, out_strobe);
      end
      tick();
    end
    if (apply_sum) begin
      atten_apply = 1'b1;
      model_targets_from_inputs();
    end
    checks++;
    if (out_strobe !== 1'b1) begin
      errors++; $display("FAIL strobe_n5: got %b want 1", out_strobe);
    end
    checks++;
    if (out_left !== 16'(el) || out_right !== 16'(er)) begin
      errors++;
      $display("FAIL sample_out: in=(%0d,%0d) got (%0d,%0d) want (%0d,%0d)",
               l, r, out_left, out_right, el, er);
    end
    tick();
    atten_apply = 1'b0;
    model_ramp();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sample_strobe = 1'b0; in_left = '0; in_right = '0;
    atten_ll = '0; atten_lr = '0; atten_rl = '0; atten_rr = '0; atten_apply = 1'b0;
    model_reset();
    tick(); tick();
    checks++;
    if (out_left !== 16'sd0 || out_right !== 16'sd0) begin
      errors++; $display("FAIL reset_out: got (%0d,%0d) want (0,0)", out_left, out_right);
    end
    checks++;
    if (out_strobe !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got strobe=%b busy=%b overrun=%b want 0", out_strobe, busy, overrun);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fade_in();
    apply(0, 255, 255, 0);
    for (int n = 0; n < 130; n++) send(16'sh4000, 16'sh2000, 1'b0);
    checks++;
    if (out_left !== 16'sh4000 || out_right !== 16'sh2000) begin
      errors++; $display("FAIL fade_settle: got (%0d,%0d) want (16384,8192)", out_left, out_right);
    end
  endtask

  task automatic test_saturation();
    apply(0, 255, 0, 255);
    for (int n = 0; n < 130; n++) send(16'($urandom), 16'($urandom), 1'b0);
    send(16'sh7000, 16'sh7000, 1'b0);
    checks++;
    if (out_left !== 16'sh7FFF || out_right !== 16'sd0) begin
      errors++; $display("FAIL sat_pos: got (%0d,%0d) want (32767,0)", out_left, out_right);
    end
    send(-16'sh7000, -16'sh7000, 1'b0);
    checks++;
    if (out_left !== -16'sd32768 || out_right !== 16'sd0) begin
      errors++; $display("FAIL sat_neg: got (%0d,%0d) want (-32768,0)", out_left, out_right);
    end
  endtask

  task automatic test_floor();
    apply(12, 255, 255, 255);
    for (int n = 0; n < 130; n++) send(16'($urandom), 16'($urandom), 1'b0);
    send(16'sh4000, 16'($urandom), 1'b0);
    checks++;
    if (out_left !== 16'sh2000) begin
      errors++; $display("FAIL half_gain: got %0d want 8192", out_left);
    end
    send(-16'sd1, 16'($urandom), 1'b0);
    checks++;
    if (out_left !== -16'sd1) begin
      errors++; $display("FAIL floor_neg: got %0d want -1", out_left);
    end
    apply(1, 255, 255, 255);
    for (int n = 0; n < 12; n++) send(16'($urandom), 16'($urandom), 1'b0);
    send(16'sh7FFF, 16'($urandom), 1'b0);
    checks++;
    if (out_left !== 16'sd30934) begin
      errors++; $display("FAIL step1_full: got %0d want 30934", out_left);
    end
  endtask

  task automatic test_apply_in_sum();
    apply(0, 255, 255, 255);
    for (int n = 0; n < 2; n++) send(16'($urandom), 16'($urandom), 1'b0);
    atten_ll = 8'd10;
    send(16'($urandom), 16'($urandom), 1'b1);
    send(16'sh4000, 16'($urandom), 1'b0);
    checks++;
    if (out_left !== 16'sd15467) begin
      errors++; $display("FAIL apply_in_sum_step: got %0d want 15467", out_left);
    end
    for (int n = 0; n < 10; n++) send(16'($urandom), 16'($urandom), 1'b0);
    send(16'sh4000, 16'($urandom), 1'b0);
    checks++;
    if (out_left !== 16'sd9213) begin
      errors++; $display("FAIL apply_in_sum_settle: got %0d want 9213", out_left);
    end
  endtask

  task automatic test_overrun();
    int el, er;
    logic signed [15:0] l, r;
    l = 16'($urandom); r = 16'($urandom);
    el = sat_ref(path_gain(int'(l), m_cur[0]) + path_gain(int'(r), m_cur[2]));
    er = sat_ref(path_gain(int'(l), m_cur[1]) + path_gain(int'(r), m_cur[3]));
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_pre: got %b want 0", overrun);
    end
    in_left = l; in_right = r; sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    tick(); tick();
    in_left = ~l; in_right = ~r; sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_set: got %b want 1", overrun);
    end
    tick();
    checks++;
    if (out_strobe !== 1'b1 || out_left !== 16'(el) || out_right !== 16'(er)) begin
      errors++;
      $display("FAIL overrun_first: strobe=%b out=(%0d,%0d) want 1 (%0d,%0d)", out_strobe, out_left, out_right, el, er);
    end
    model_ramp();
    tick();
    checks++;
    if (out_strobe !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL overrun_drop: strobe=%b busy=%b want 0 0", out_strobe, busy);
    end
    send(16'($urandom), 16'($urandom), 1'b0);
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_sticky: got %b want 1", overrun);
    end
  endtask

  task automatic test_reset_mid();
    in_left = 16'sh1234; in_right = 16'sh0567; sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_strobe !== 1'b0 || busy !== 1'b0 || out_left !== 16'sd0 || out_right !== 16'sd0) begin
      errors++;
      $display("FAIL reset_mid: strobe=%b busy=%b out=(%0d,%0d) want 0 0 (0,0)", out_strobe, busy, out_left, out_right);
    end
    model_reset();
    tick(); tick();
    checks++;
    if (out_strobe !== 1'b0) begin
      errors++; $display("FAIL reset_mid_strobe: got %b want 0", out_strobe);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL reset_mid_overrun: got %b want 0", overrun);
    end
    send(16'sh4000, 16'sh2000, 1'b0);
    checks++;
    if (out_left !== 16'sd0 || out_right !== 16'sd0) begin
      errors++; $display("FAIL reset_mid_muted: got (%0d,%0d) want (0,0)", out_left, out_right);
    end
    apply(0, 0, 0, 0);
    for (int n = 0; n < 4; n++) send(16'($urandom), 16'($urandom), 1'b0);
  endtask

  initial begin
    test_reset();
    test_fade_in();
    test_saturation();
    test_floor();
    test_apply_in_sum();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_attenuator.md
# audio_attenuator

Stereo attenuation matrix sitting directly downstream of the audio player: takes each stereo sample pair the player emits and applies the CD-i 2×2 volume matrix (L→L, L→R, R→L, R→R) in 0.5 dB steps. Attenuation changes are ramped one step per sample to avoid clicks. A single shared multiplier is time-multiplexed across the four paths. Output is a saturated 16-bit stereo pair with a one-cycle strobe toward the DAC/mixer.

## Interface
- no parameters
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sample_strobe  in  1  one-cycle pulse: in_left/in_right valid this cycle
- in_left  in  16  signed sample
- in_right  in  16  signed sample
- atten_ll, atten_lr, atten_rl, atten_rr  in  8 each  target attenuation code per path (xy = source x to output y)
- atten_apply  in  1  one-cycle pulse: latch all four atten_* as new targets
- out_left  out  16  signed result
- out_right  out  16  signed result
- out_strobe  out  1  one-cycle pulse: out_* updated this cycle
- busy  out  1  computation in progress
- overrun  out  1  sticky: sample_strobe arrived while busy

## Operation
- Code meaning: 0..127 = code×0.5 dB attenuation; ≥128 = mute (gain 0). Internally, targets are clamped to 128.
- Gain = MANT[code%12] >> (code/12). MANT is Q1.15: 32768, 30935, 29205, 27571, 26029, 24573, 23198, 21900, 20675, 19519, 18427, 17396.
- Product p = in × MANT (signed 17-bit mantissa, 33-bit product), then arithmetic right shift by 15 + code/12. Shifting floors toward −inf.
- out_left = sat16(p_ll + p_rl). out_right = sat16(p_lr + p_rr). Sums use 18-bit width; saturate to [−32768, 32767].
- FSM states:
  - IDLE: sample_strobe captures both inputs, goes to MUL_LL.
  - MUL_LL → MUL_RL → MUL_LR → MUL_RR: one product per state.
  - SUM: drive outputs and out_strobe, apply ramp step, return to IDLE.
- Ramp: each path has a current code cur_xy (0..128). In SUM, after outputs are computed, each cur_xy moves ±1 toward its target; no change if equal. Products always use cur_xy, never the target.
- atten_apply updates targets in any state. If it coincides with SUM, the new targets govern that SUM's ramp step.
- sample_strobe while busy (any state other than IDLE): sample is dropped and overrun is set. overrun clears only on reset.
- Reset mid-operation: FSM returns to IDLE, any in-flight result is discarded, no out_strobe.

## Timing
- Reset values:
  - out_left = 0, out_right = 0, out_strobe = 0, busy = 0, overrun = 0
  - all cur_xy = 128 and all targets = 128 (muted). The first atten_apply produces a fade-in.
- Latency: sample_strobe at cycle N → out_strobe and new out_* at cycle N+5. out_* hold until the next SUM.
- busy is high in cycles N+1..N+5. A sample_strobe at N+6 is accepted.
- A full ramp from 0 to mute takes 128 accepted samples.

## Structure
- Package audio_atten_pkg holds:
  - the state enum (IDLE, MUL_LL, MUL_RL, MUL_LR, MUL_RR, SUM)
  - localparam MUTE_CODE = 128
  - the MANT table as a function mant_lookup(code) returning {mantissa, shift}
- Sub-module audio_gain_mul: combinational signed×Q1.15 multiply plus shift, instantiated once and muxed by the FSM.
- The ramp (4× up/down compare) stays inline.

## Test plan
- Reset, atten_apply ll=rr=0, lr=rl=0xFF, then 128 samples of L=0x4000 / R=0x2000: outputs ramp up from 0 in 128 steps and settle at out_left=0x4000, out_right=0x2000.
- Settled ll=rl=0, lr=rr=mute, L=R=0x7000: out_left=0x7FFF (saturated), out_right=0. Same with L=R=−0x7000: out_left=−32768.
- Settled ll=12 (6 dB), L=0x4000 → out_left=0x2000. L=−1 → out_left=−1 (floor). ll=1, L=0x7FFF → out_left=30934.
- sample_strobe at N and N+3: only the first produces out_strobe (at N+5), overrun goes to 1. A strobe at N+6 is accepted, with its result at N+11.
- atten_apply (ll 0→10) in the same cycle as SUM: cur_ll steps toward 10 that cycle. After 10 samples it is stable, and the output equals in×MANT[10]>>15.
- Assert reset_n low at cycle N+3 of a computation: no out_strobe, outputs 0, busy 0 immediately. After release, the next sample processes normally with muted gains.
